// File: rtl/map_hub_seq.sv
`default_nettype none
//============================================================================
// Module   : map_hub_seq
// Brief    : Registered mapper-output selector. Resolves map_idx against a
//            writable slot table and blanks map_out for HOLD+1 cycles
//            whenever the selection changes, so the bus never glitches.
//            Optional switch counter: define MAP_HUB_SEQ_SWCNT_EN.
// Revision : 1.0  initial release
//============================================================================

`ifndef BW_MAP_OUT
`define BW_MAP_OUT 8
`endif

module map_hub_seq #(
    parameter int SLOTS = 16,
    parameter int IDX_W = 10,
    parameter int OUT_W = `BW_MAP_OUT,
    parameter int HOLD  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IDX_W-1:0]       map_idx,
    input  logic [SLOTS*OUT_W-1:0] slot_out,
    input  logic [OUT_W-1:0]       nom_out,
    input  logic                   tbl_we,
    input  logic [4:0]             tbl_addr,
    input  logic [IDX_W-1:0]       tbl_idx,
    input  logic                   tbl_vld,
    output logic [OUT_W-1:0]       map_out,
    output logic [5:0]             cur_sel,
    output logic                   switching,
    output logic [7:0]             sw_cnt
);

    localparam logic [5:0] c_nom     = 6'd32;
    localparam logic [7:0] c_hold_m1 = 8'(HOLD - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t             r_state;
    logic [5:0]         r_cur_sel;
    logic [5:0]         r_pend;
    logic [7:0]         r_cnt;
    logic [OUT_W-1:0]   r_map_out;

    logic               r_tbl_vld [SLOTS];
    logic [IDX_W-1:0]   r_tbl_idx [SLOTS];

    logic [SLOTS-1:0]   w_hit;
    logic [5:0]         w_target;
    logic [OUT_W-1:0]   w_sel_data;
    logic               w_commit;

    // Full 5-bit address compare: entries at or beyond SLOTS never match.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_tbl
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_tbl_vld[gi] <= 1'b0;
                    r_tbl_idx[gi] <= '0;
                end else if (tbl_we && (tbl_addr == 5'(gi))) begin
                    r_tbl_vld[gi] <= tbl_vld;
                    r_tbl_idx[gi] <= tbl_idx;
                end
            end

            assign w_hit[gi] = r_tbl_vld[gi] && (r_tbl_idx[gi] == map_idx);
        end
    endgenerate

    // Scan high to low so the lowest matching slot wins.
    always_comb begin
        w_target = c_nom;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_target = 6'(i);
            end
        end
    end

    always_comb begin
        w_sel_data = nom_out;
        for (int i = 0; i < SLOTS; i++) begin
            if (r_cur_sel == 6'(i)) begin
                w_sel_data = slot_out[i*OUT_W +: OUT_W];
            end
        end
    end

    assign w_commit = (r_state == ST_BLANK) && (w_target == r_pend) && (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_cur_sel <= c_nom;
            r_pend    <= c_nom;
            r_cnt     <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_target != r_cur_sel) begin
                        r_pend  <= w_target;
                        r_cnt   <= c_hold_m1;
                        r_state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    // A moving target restarts the window; no early abort.
                    if (w_target != r_pend) begin
                        r_pend <= w_target;
                        r_cnt  <= c_hold_m1;
                    end else if (w_commit) begin
                        r_cur_sel <= r_pend;
                        r_state   <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_map_out <= '0;
        end else if ((r_state == ST_RUN) && (w_target == r_cur_sel)) begin
            r_map_out <= w_sel_data;
        end else begin
            r_map_out <= '0;
        end
    end

`ifdef MAP_HUB_SEQ_SWCNT_EN
    logic [7:0] r_sw_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_cnt <= 8'd0;
        end else if (w_commit && (r_sw_cnt != 8'hFF)) begin
            r_sw_cnt <= r_sw_cnt + 8'd1;
        end
    end

    assign sw_cnt = r_sw_cnt;
`else
    assign sw_cnt = 8'd0;
`endif

    assign map_out   = r_map_out;
    assign cur_sel   = r_cur_sel;
    assign switching = (r_state == ST_BLANK);

endmodule

`default_nettype wire

// File: tb/tb_map_hub_seq.sv
`default_nettype none
//============================================================================
// Module   : tb_map_hub_seq
// Brief    : Directed scoreboard bench for map_hub_seq.
// Revision : 1.0  initial release
//============================================================================

module tb_map_hub_seq;

    localparam int SLOTS = 16;
    localparam int IDX_W = 10;
    localparam int OUT_W = 8;
    localparam int HOLD  = 4;
    localparam logic [5:0] NOM = 6'd32;
    localparam logic [7:0] NOMV = 8'hA5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [IDX_W-1:0]       map_idx;
    logic [SLOTS*OUT_W-1:0] slot_out;
    logic [OUT_W-1:0]       nom_out;
    logic                   tbl_we;
    logic [4:0]             tbl_addr;
    logic [IDX_W-1:0]       tbl_idx;
    logic                   tbl_vld;
    logic [OUT_W-1:0]       map_out;
    logic [5:0]             cur_sel;
    logic                   switching;
    logic [7:0]             sw_cnt;

    logic [OUT_W-1:0]       words [SLOTS];

    always #5 clk = ~clk;

    always_comb begin
        slot_out = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_out[i*OUT_W +: OUT_W] = words[i];
        end
    end

    map_hub_seq #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W),
        .OUT_W (OUT_W),
        .HOLD  (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .map_idx   (map_idx),
        .slot_out  (slot_out),
        .nom_out   (nom_out),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_idx   (tbl_idx),
        .tbl_vld   (tbl_vld),
        .map_out   (map_out),
        .cur_sel   (cur_sel),
        .switching (switching),
        .sw_cnt    (sw_cnt)
    );

    typedef struct packed {
        logic [OUT_W-1:0] out;
        logic [5:0]       sel;
        logic             sw;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    // Push the expectation for the coming edge, then compare just after it.
    task automatic cyc(input logic [OUT_W-1:0] e_out, input logic [5:0] e_sel, input logic e_sw);
        exp_t e;
        sb.push_back(exp_t'{out: e_out, sel: e_sel, sw: e_sw});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        assert (map_out === e.out) else begin
            bad++;
            $error("FAIL map_out: got %h want %h t=%0t", map_out, e.out, $time);
        end
        total++;
        assert (cur_sel === e.sel) else begin
            bad++;
            $error("FAIL cur_sel: got %0d want %0d t=%0t", cur_sel, e.sel, $time);
        end
        total++;
        assert (switching === e.sw) else begin
            bad++;
            $error("FAIL switching: got %b want %b t=%0t", switching, e.sw, $time);
        end
    endtask

    // Edge 0 samples the new target: HOLD+1 blank edges, then new data.
    task automatic window(input logic [5:0] old_sel, input logic [5:0] new_sel, input logic [OUT_W-1:0] new_data);
        for (int k = 0; k < HOLD; k++) begin
            cyc('0, old_sel, 1'b1);
        end
        cyc('0, new_sel, 1'b0);
        cyc(new_data, new_sel, 1'b0);
    endtask

    task automatic chk_cnt(input int n);
        logic [7:0] e;
`ifdef MAP_HUB_SEQ_SWCNT_EN
        e = 8'(n);
`else
        e = 8'd0;
`endif
        total++;
        assert (sw_cnt === e) else begin
            bad++;
            $error("FAIL sw_cnt: got %0d want %0d t=%0t", sw_cnt, e, $time);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [IDX_W-1:0] idx, input logic v);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_idx  = idx;
        tbl_vld  = v;
    endtask

    initial begin
        for (int i = 0; i < SLOTS; i++) begin
            words[i] = 8'(8'h30 + i * 7);
        end
        rst_n    = 1'b0;
        map_idx  = 10'd3;
        nom_out  = NOMV;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_idx  = '0;
        tbl_vld  = 1'b0;

        // Reset, then nominal output one edge after release
        cyc('0, NOM, 1'b0);
        cyc('0, NOM, 1'b0);
        chk_cnt(0);
        rst_n = 1'b1;
        cyc(NOMV, NOM, 1'b0);
        cyc(NOMV, NOM, 1'b0);

        // Write entry 2 with matching lookup in the same cycle: pre-write table used
        wr(5'd2, 10'd7, 1'b1);
        map_idx = 10'd7;
        cyc(NOMV, NOM, 1'b0);
        tbl_we = 1'b0;
        window(NOM, 6'd2, words[2]);
        chk_cnt(1);

        // Steady state: one-cycle latency on source data change
        words[2] = 8'h5C;
        cyc(8'h5C, 6'd2, 1'b0);

        // Duplicates resolve to lowest slot
        wr(5'd5, 10'd66, 1'b1);
        cyc(8'h5C, 6'd2, 1'b0);
        wr(5'd1, 10'd66, 1'b1);
        cyc(8'h5C, 6'd2, 1'b0);
        tbl_we  = 1'b0;
        map_idx = 10'd66;
        window(6'd2, 6'd1, words[1]);
        chk_cnt(2);

        // Invalidate entry 1: one window, then slot 5
        wr(5'd1, 10'd66, 1'b0);
        cyc(words[1], 6'd1, 1'b0);
        tbl_we = 1'b0;
        window(6'd1, 6'd5, words[5]);
        chk_cnt(3);

        // Retarget at window cycle 2 restarts the window; ch2 never shows
        wr(5'd4, 10'd99, 1'b1);
        cyc(words[5], 6'd5, 1'b0);
        tbl_we  = 1'b0;
        map_idx = 10'd7;
        cyc('0, 6'd5, 1'b1);
        cyc('0, 6'd5, 1'b1);
        map_idx = 10'd99;
        window(6'd5, 6'd4, words[4]);
        chk_cnt(4);

        // Unmatched index falls back to nominal
        map_idx = 10'd500;
        window(6'd4, NOM, NOMV);
        chk_cnt(5);

        // Out-of-range write is ignored even though its idx matches
        wr(5'd16, 10'd500, 1'b1);
        cyc(NOMV, NOM, 1'b0);
        tbl_we = 1'b0;
        cyc(NOMV, NOM, 1'b0);
        cyc(NOMV, NOM, 1'b0);
        chk_cnt(5);

        // Reset mid-BLANK aborts the switch and clears the table
        map_idx = 10'd99;
        cyc('0, NOM, 1'b1);
        cyc('0, NOM, 1'b1);
        rst_n = 1'b0;
        cyc('0, NOM, 1'b0);
        chk_cnt(0);
        rst_n = 1'b1;
        cyc(NOMV, NOM, 1'b0);
        cyc(NOMV, NOM, 1'b0);
        cyc(NOMV, NOM, 1'b0);
        chk_cnt(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
